gon_bus_scheduler: RTL and testbench

Sequencer for one GON gather bus. It loads the per-column multicast IDs through the bus ID scan chain, then steps the bus `tag` across a programmed tag range. For each tag it counts a fixed number of completed transfers (`slave_valid & slave_ready`) before advancing. It sits between the PE-array top-level controller and one GON_Bus instance, driving that bus's `tag`, `set_id` and `ID_scan_in`.

---
 rtl/gon_pkg.sv | 26 ++
 rtl/gon_scan_loader.sv | 64 ++++++
 rtl/gon_bus_scheduler.sv | 138 +++++++++++++
 tb/tb_gon_bus_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gon_pkg.sv
// gon_pkg
// Shared types and constants for the GON gather-bus scheduler.
//   sched_state_t      : scheduler FSM states (IDLE, SCAN, RUN)
//   GON_SCHED_CNT_BITS : default width of the transfers-per-tag count
// NUMS_PE_COL and XID_BITS normally come from the PE-array configuration
// header; the fallbacks below let the scheduler build on its own.

`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif

`ifndef XID_BITS
`define XID_BITS 4
`endif

package gon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    localparam int GON_SCHED_CNT_BITS = 8;

endpackage

// File: rtl/gon_scan_loader.sv
// gon_scan_loader
// Feeds the bus ID scan chain. Every accepted ID is registered onto
// ID_scan_in with a one-cycle set_id strobe, so the chain shifts exactly
// once per accepted ID. The first ID ends up in the farthest controller.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load_start     : clears the load count at the start of a new load
//   scan_active    : high while the owning FSM is in SCAN
//   cfg_id_valid   : ID stream valid
//   cfg_id         : ID stream data
//   cfg_id_ready   : ID stream ready (combinational)
//   load_last      : the current accept is the final one of the load
//   set_id         : chain shift strobe (registered)
//   ID_scan_in     : chain scan data (registered, holds its last value)

module gon_scan_loader
    import gon_pkg::*;
#(
    parameter int NUMS_MASTER = `NUMS_PE_COL,
    parameter int ID_SIZE     = `XID_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               scan_active,
    input  logic               cfg_id_valid,
    input  logic [ID_SIZE-1:0] cfg_id,
    output logic               cfg_id_ready,
    output logic               load_last,
    output logic               set_id,
    output logic [ID_SIZE-1:0] ID_scan_in
);

    localparam int LC_BITS = $clog2(NUMS_MASTER + 1);
    localparam logic [LC_BITS-1:0] LOAD_MAX = LC_BITS'(NUMS_MASTER);

    logic [LC_BITS-1:0] load_cnt;
    logic               accept;

    // Ready stays combinational so the stream can be accepted in the very
    // first SCAN cycle and stops as soon as every controller has an ID.
    assign cfg_id_ready = scan_active && (load_cnt < LOAD_MAX);
    assign accept       = cfg_id_valid && cfg_id_ready;
    assign load_last    = accept && (load_cnt == LOAD_MAX - LC_BITS'(1));

    // Shift strobe and data follow an accept by one cycle; the data
    // register is deliberately not cleared after the load finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt   <= '0;
            set_id     <= 1'b0;
            ID_scan_in <= '0;
        end else begin
            set_id <= accept;
            if (load_start) begin
                load_cnt <= '0;
            end else if (accept) begin
                load_cnt   <= load_cnt + LC_BITS'(1);
                ID_scan_in <= cfg_id;
            end
        end
    end

endmodule

// File: rtl/gon_bus_scheduler.sv
// gon_bus_scheduler
// Sequencer for one GON gather bus: loads the multicast IDs through the
// scan chain, then sweeps the bus tag from tag_first to tag_last (wrapping
// modulo 2^ID_SIZE), holding each tag for xfers_per_tag completed transfers.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cfg_start                     : begin an ID load (IDLE only, wins over run_start)
//   cfg_id_valid/cfg_id/cfg_id_ready : ID stream handshake
//   cfg_done                      : pulse with the final set_id strobe
//   run_start                     : begin a tag sweep (IDLE only)
//   tag_first/tag_last            : sweep range, latched on run_start
//   xfers_per_tag                 : transfers per tag, latched on run_start
//   run_done                      : pulse one cycle after the final transfer
//   busy                          : high outside IDLE
//   tag/set_id/ID_scan_in         : drive the GON bus
//   bus_slave_valid/bus_slave_ready : monitored bus handshake

module gon_bus_scheduler
    import gon_pkg::*;
#(
    parameter int NUMS_MASTER = `NUMS_PE_COL,
    parameter int ID_SIZE     = `XID_BITS,
    parameter int CNT_BITS    = GON_SCHED_CNT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_id_valid,
    input  logic [ID_SIZE-1:0]  cfg_id,
    output logic                cfg_id_ready,
    output logic                cfg_done,
    input  logic                run_start,
    input  logic [ID_SIZE-1:0]  tag_first,
    input  logic [ID_SIZE-1:0]  tag_last,
    input  logic [CNT_BITS-1:0] xfers_per_tag,
    output logic                run_done,
    output logic                busy,
    output logic [ID_SIZE-1:0]  tag,
    output logic                set_id,
    output logic [ID_SIZE-1:0]  ID_scan_in,
    input  logic                bus_slave_valid,
    input  logic                bus_slave_ready
);

    sched_state_t        state;
    logic [CNT_BITS-1:0] xfer_cnt;
    logic [CNT_BITS-1:0] xfers_lat;
    logic [ID_SIZE-1:0]  tag_last_lat;
    logic                load_start;
    logic                load_last;
    logic                fire;

    assign load_start = (state == IDLE) && cfg_start;
    assign fire       = bus_slave_valid && bus_slave_ready;

    gon_scan_loader #(
        .NUMS_MASTER (NUMS_MASTER),
        .ID_SIZE     (ID_SIZE)
    ) u_scan_loader (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .scan_active  (state == SCAN),
        .cfg_id_valid (cfg_id_valid),
        .cfg_id       (cfg_id),
        .cfg_id_ready (cfg_id_ready),
        .load_last    (load_last),
        .set_id       (set_id),
        .ID_scan_in   (ID_scan_in)
    );

    // Main FSM. busy is registered alongside state so it always equals
    // (state != IDLE). The final accept of a load returns to IDLE on the
    // same edge that raises the last set_id, so cfg_done lines up with it.
    // A zero transfer count finishes after a single RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            tag          <= '0;
            cfg_done     <= 1'b0;
            run_done     <= 1'b0;
            xfer_cnt     <= '0;
            xfers_lat    <= '0;
            tag_last_lat <= '0;
        end else begin
            cfg_done <= 1'b0;
            run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else if (run_start) begin
                        tag          <= tag_first;
                        tag_last_lat <= tag_last;
                        xfers_lat    <= xfers_per_tag;
                        xfer_cnt     <= '0;
                        state        <= RUN;
                        busy         <= 1'b1;
                    end
                end
                SCAN: begin
                    if (load_last) begin
                        cfg_done <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                RUN: begin
                    if (xfers_lat == '0) begin
                        run_done <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (fire) begin
                        if (xfer_cnt == xfers_lat - CNT_BITS'(1)) begin
                            xfer_cnt <= '0;
                            if (tag == tag_last_lat) begin
                                run_done <= 1'b1;
                                state    <= IDLE;
                                busy     <= 1'b0;
                            end else begin
                                tag <= tag + ID_SIZE'(1);
                            end
                        end else begin
                            xfer_cnt <= xfer_cnt + CNT_BITS'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gon_bus_scheduler.sv
// tb_gon_bus_scheduler
// Self-checking bench for gon_bus_scheduler (NUMS_MASTER=8, ID_SIZE=4).
// Inputs are driven and outputs sampled on the falling clock edge. The
// expected tag for the k-th transfer is first + k/xfers (mod 16), and the
// scan chain is modelled as a plain shift array fed by set_id/ID_scan_in.

module tb_gon_bus_scheduler;

    localparam int NM   = 8;
    localparam int IDW  = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start;
    logic            cfg_id_valid;
    logic [IDW-1:0]  cfg_id;
    logic            cfg_id_ready;
    logic            cfg_done;
    logic            run_start;
    logic [IDW-1:0]  tag_first;
    logic [IDW-1:0]  tag_last;
    logic [CNTW-1:0] xfers_per_tag;
    logic            run_done;
    logic            busy;
    logic [IDW-1:0]  tag;
    logic            set_id;
    logic [IDW-1:0]  ID_scan_in;
    logic            bus_slave_valid;
    logic            bus_slave_ready;

    int n_checks = 0;
    int n_errors = 0;

    gon_bus_scheduler #(
        .NUMS_MASTER (NM),
        .ID_SIZE     (IDW),
        .CNT_BITS    (CNTW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_id_valid    (cfg_id_valid),
        .cfg_id          (cfg_id),
        .cfg_id_ready    (cfg_id_ready),
        .cfg_done        (cfg_done),
        .run_start       (run_start),
        .tag_first       (tag_first),
        .tag_last        (tag_last),
        .xfers_per_tag   (xfers_per_tag),
        .run_done        (run_done),
        .busy            (busy),
        .tag             (tag),
        .set_id          (set_id),
        .ID_scan_in      (ID_scan_in),
        .bus_slave_valid (bus_slave_valid),
        .bus_slave_ready (bus_slave_ready)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch
    task automatic checkOutput(input string name, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
        end
    endtask

    // Drives the monitored bus handshake for the next rising edge
    task automatic applyStimulus(input bit v, input bit r);
        bus_slave_valid = v;
        bus_slave_ready = r;
    endtask

    // Runs one full ID load and compares the chain contents against a
    // shift-array model. Optionally raises run_start with cfg_start.
    task automatic run_scan(input bit stall_mode, input bit random_ids, input bit with_run_start);
        logic [IDW-1:0] ids [NM];
        logic [IDW-1:0] mc  [NM];
        logic [IDW-1:0] tag_before;
        int  sent;
        int  pulses;
        int  cycles;
        bit  toggle;
        bit  accepted;
        for (int i = 0; i < NM; i++) begin
            ids[i] = random_ids ? IDW'($urandom_range(0, 15)) : IDW'(i + 1);
            mc[i]  = '0;
        end
        @(negedge clk);
        tag_before = tag;
        cfg_start  = 1'b1;
        if (with_run_start) begin
            run_start     = 1'b1;
            tag_first     = tag_before + IDW'(5);
            tag_last      = tag_before + IDW'(6);
            xfers_per_tag = 8'd1;
        end
        @(negedge clk);
        cfg_start = 1'b0;
        run_start = 1'b0;
        checkOutput("scan_ready_after_start", cfg_id_ready, 1);
        checkOutput("scan_busy", busy, 1);
        checkOutput("scan_tag_held_on_entry", tag, tag_before);
        sent   = 0;
        pulses = 0;
        cycles = 0;
        toggle = 1'b1;
        while (pulses < NM && cycles < 200) begin
            cfg_id_valid = (sent < NM) && (stall_mode ? toggle : 1'b1);
            toggle       = ~toggle;
            cfg_id       = ids[(sent < NM) ? sent : NM - 1];
            accepted     = cfg_id_valid && cfg_id_ready;
            @(negedge clk);
            cycles++;
            if (accepted) sent++;
            checkOutput("set_id_follows_accept", set_id, accepted);
            if (set_id) begin
                pulses++;
                for (int k = NM - 1; k > 0; k--) mc[k] = mc[k-1];
                mc[0] = ID_scan_in;
                checkOutput("scan_in_value", ID_scan_in, ids[pulses-1]);
            end
            checkOutput("cfg_done_timing", cfg_done, (set_id && pulses == NM) ? 1 : 0);
            checkOutput("tag_stable_in_scan", tag, tag_before);
        end
        cfg_id_valid = 1'b0;
        checkOutput("scan_pulse_count", pulses, NM);
        checkOutput("scan_idle_after_load", busy, 0);
        checkOutput("scan_ready_low_after_load", cfg_id_ready, 0);
        for (int i = 0; i < NM; i++) begin
            checkOutput($sformatf("chain_mc%0d", i), mc[i], ids[NM-1-i]);
        end
        @(negedge clk);
        checkOutput("set_id_quiet_after_load", set_id, 0);
        checkOutput("cfg_done_single_pulse", cfg_done, 0);
        checkOutput("scan_in_holds", ID_scan_in, ids[NM-1]);
        checkOutput("tag_after_scan", tag, tag_before);
    endtask

    // Runs one tag sweep (xfers >= 1) against the arithmetic tag model
    task automatic run_sweep(input int first, input int last, input int xfers, input bit rand_bus);
        int  total;
        int  fires;
        int  cycles;
        bit  v;
        bit  r;
        bit  fired;
        total = (((last - first) & 15) + 1) * xfers;
        @(negedge clk);
        tag_first     = IDW'(first);
        tag_last      = IDW'(last);
        xfers_per_tag = CNTW'(xfers);
        run_start     = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        checkOutput("run_busy", busy, 1);
        checkOutput("run_first_tag", tag, first);
        fires  = 0;
        cycles = 0;
        while (fires < total && cycles < 2000) begin
            v = rand_bus ? 1'($urandom_range(0, 1)) : 1'b1;
            r = rand_bus ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(v, r);
            fired = v && r;
            @(negedge clk);
            cycles++;
            if (fired) fires++;
            if (fires < total) begin
                checkOutput("sweep_tag", tag, (first + fires / xfers) & 15);
                checkOutput("run_done_early", run_done, 0);
                checkOutput("set_id_in_run", set_id, 0);
            end
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_fire_count", fires, total);
        checkOutput("run_done_pulse", run_done, 1);
        checkOutput("run_idle_after", busy, 0);
        checkOutput("run_final_tag", tag, last);
        @(negedge clk);
        checkOutput("run_done_one_cycle", run_done, 0);
        checkOutput("run_tag_holds", tag, last);
    endtask

    initial begin
        int first;
        int last;
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_id_valid  = 1'b0;
        cfg_id        = '0;
        run_start     = 1'b0;
        tag_first     = '0;
        tag_last      = '0;
        xfers_per_tag = '0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        checkOutput("reset_tag", tag, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_set_id", set_id, 0);
        checkOutput("reset_scan_in", ID_scan_in, 0);
        checkOutput("reset_cfg_done", cfg_done, 0);
        checkOutput("reset_run_done", run_done, 0);
        checkOutput("reset_cfg_ready", cfg_id_ready, 0);
        rst = 1'b0;

        // ID loads: directed 1..8, then random IDs with valid toggling
        run_scan(1'b0, 1'b0, 1'b0);
        run_scan(1'b1, 1'b1, 1'b0);

        // Directed sweeps: plain range, then wrap through 15 -> 0
        run_sweep(2, 4, 3, 1'b0);
        run_sweep(15, 0, 1, 1'b0);

        // Zero transfers per tag: done two cycles after run_start
        @(negedge clk);
        tag_first     = 4'd7;
        tag_last      = 4'd9;
        xfers_per_tag = 8'd0;
        run_start     = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("zero_xfer_busy", busy, 1);
        checkOutput("zero_xfer_tag", tag, 7);
        checkOutput("zero_xfer_not_done_yet", run_done, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("zero_xfer_done", run_done, 1);
        checkOutput("zero_xfer_idle", busy, 0);
        checkOutput("zero_xfer_tag_held", tag, 7);
        @(negedge clk);
        checkOutput("zero_xfer_done_once", run_done, 0);

        // cfg_start and run_start together: the load wins
        run_scan(1'b0, 1'b1, 1'b1);

        // Randomised sweeps with random bus back-pressure
        for (int n = 0; n < 6; n++) begin
            first = $urandom_range(0, 15);
            last  = (first + $urandom_range(0, 3)) & 15;
            run_sweep(first, last, $urandom_range(1, 4), 1'b1);
        end

        // Reset in the middle of a sweep after two transfers
        @(negedge clk);
        tag_first     = 4'd2;
        tag_last      = 4'd4;
        xfers_per_tag = 8'd3;
        run_start     = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        applyStimulus(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_tag", tag, 2);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_reset_tag", tag, 0);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_run_done", run_done, 0);
        checkOutput("mid_reset_set_id", set_id, 0);
        checkOutput("mid_reset_scan_in", ID_scan_in, 0);
        checkOutput("mid_reset_cfg_done", cfg_done, 0);
        @(negedge clk);
        checkOutput("post_reset_no_done", run_done, 0);
        checkOutput("post_reset_idle", busy, 0);
        run_sweep(2, 4, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
